encrypt_sequencer: RTL and testbench

//   Hardware sequencer for the program-1 message encryptor.
//   - Reads the run config from data memory: pre_length @61, LFSR taps @62, LFSR init @63.
//   - Builds the 64-byte padded plaintext stream. Each byte is the ASCII character minus 0x20, or 0 for padding.
//   - XORs each byte with a 7-bit Fibonacci LFSR and puts even parity of bits[6:0] into bit 7.
//   - Writes the 64 results to memory 64..127, then raises Ack.
//   - Connects to TopLevel's data memory (DM) port; is a drop-in replacement for the software program-1 run.

---
 rtl/encrypt_pkg.sv | 36 +++
 rtl/lfsr7_step.sv | 37 +++
 rtl/encrypt_sequencer.sv | 117 +++++++++++
 tb/tb_encrypt_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pkg.sv
// Shared types, address map and bit-level helpers for the program-1 encryption sequencer.
// Used by the sequencer top and its LFSR step sub-module.
package encrypt_pkg;

   localparam int         NUM_OUT   = 64;
   localparam int         MSG_MAX   = 52;
   localparam logic [7:0] MSG_BASE  = 8'd0;
   localparam logic [7:0] CFG_BASE  = 8'd61;
   localparam logic [7:0] OUT_BASE  = 8'd64;
   localparam logic [7:0] ASCII_OFS = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      HDR_RD,
      HDR_CAP,
      CH_RD,
      CH_WR,
      DONE
   } state_t;

   function automatic logic [6:0] lfsr_next(input logic [6:0] lfsr, input logic [6:0] taps);
      return {lfsr[5:0], ^(lfsr & taps)};
   endfunction

   function automatic logic [7:0] add_parity(input logic [7:0] e);
      return {^e[6:0], e[6:0]};
   endfunction

   // Message window test done at 8 bits so a large pre never wraps into the window.
   function automatic logic is_msg(input logic [5:0] idx, input logic [7:0] pre);
      logic [7:0] off;
      off = {2'b00, idx} - pre;
      return ({2'b00, idx} >= pre) && (off < 8'(MSG_MAX));
   endfunction

endpackage

// File: rtl/lfsr7_step.sv
// 7-bit Fibonacci LFSR register with a parallel load and a single-step advance enable.
// Load takes priority over advance.
module lfsr7_step
   import encrypt_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       i_load,
   input  logic [6:0] i_load_val,
   input  logic       i_adv,
   input  logic [6:0] i_taps,
   output logic [6:0] o_state
);

   logic [6:0] r_state;
   logic [6:0] w_next;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      if (i_load)
         w_next = i_load_val;
      else if (i_adv)
         w_next = lfsr_next(r_state, i_taps);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         r_state <= '0;
      else
         r_state <= w_next;
   end

   assign o_state = r_state;

endmodule

// File: rtl/encrypt_sequencer.sv
// Program-1 encryption sequencer: loads config from data memory, encrypts the padded message
// with a 7-bit LFSR plus parity tag, writes 64 bytes to OUT_BASE and raises Ack.
module encrypt_sequencer
   import encrypt_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   output logic          Ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data,
   input  logic [7:0]    mem_rd_data
);

   state_t     r_state, w_next;
   logic [1:0] r_hdr_idx;
   logic [5:0] r_i;
   logic [7:0] r_pre;
   logic [6:0] r_taps;

   logic       w_ld, w_adv;
   logic [6:0] w_lfsr;
   logic [7:0] w_p, w_e;

   lfsr7_step u_lfsr (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_load     (w_ld),
      .i_load_val (mem_rd_data[6:0]),
      .i_adv      (w_adv),
      .i_taps     (r_taps),
      .o_state    (w_lfsr)
   );

   always_comb begin
      w_next      = r_state;
      w_ld        = 1'b0;
      w_adv       = 1'b0;
      w_p         = 8'h00;
      w_e         = 8'h00;
      Ack         = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = 8'h00;
      case (r_state)
         IDLE:    w_next = HDR_RD;
         HDR_RD: begin
            mem_addr = AW'(CFG_BASE + {6'b0, r_hdr_idx});
            w_next   = HDR_CAP;
         end
         HDR_CAP: begin
            if (r_hdr_idx == 2'd2) begin
               w_ld   = 1'b1;
               w_next = is_msg(6'd0, r_pre) ? CH_RD : CH_WR;
            end else begin
               w_next = HDR_RD;
            end
         end
         CH_RD: begin
            mem_addr = AW'(MSG_BASE + ({2'b00, r_i} - r_pre));
            w_next   = CH_WR;
         end
         CH_WR: begin
            // Read data issued in CH_RD is valid here for message bytes.
            if (is_msg(r_i, r_pre))
               w_p = mem_rd_data - ASCII_OFS;
            w_e         = w_p ^ {1'b0, w_lfsr};
            mem_wr_data = add_parity(w_e);
            mem_addr    = AW'(OUT_BASE + {2'b00, r_i});
            mem_wr_en   = 1'b1;
            w_adv       = 1'b1;
            if (r_i == 6'(NUM_OUT - 1))
               w_next = DONE;
            else
               w_next = is_msg(r_i + 6'd1, r_pre) ? CH_RD : CH_WR;
         end
         DONE:    Ack = 1'b1;
         default: w_next = IDLE;
      endcase
      if (Start)
         w_next = IDLE;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_hdr_idx <= '0;
         r_i       <= '0;
         r_pre     <= '0;
         r_taps    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               r_hdr_idx <= '0;
               r_i       <= '0;
            end
            HDR_CAP: begin
               if (r_hdr_idx == 2'd0)
                  r_pre <= mem_rd_data;
               if (r_hdr_idx == 2'd1)
                  r_taps <= mem_rd_data[6:0];
               r_hdr_idx <= r_hdr_idx + 2'd1;
            end
            CH_WR: begin
               if (r_i != 6'(NUM_OUT - 1))
                  r_i <= r_i + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Self-checking bench for encrypt_sequencer: behavioural memory plus a plain-arithmetic model
// of the encrypted stream, write timing and message read addresses.
module tb_encrypt_sequencer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Ack;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [7:0] mem_rd_data;

   encrypt_sequencer #(.AW(8)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Ack         (Ack),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   always #5 Clk = ~Clk;

   // Data memory with synchronous read; preloaded from init_mem on do_load.
   logic [7:0] mem      [256];
   logic [7:0] init_mem [256];
   logic       do_load = 1'b0;
   logic [7:0] rd_q;

   always @(posedge Clk) begin
      if (do_load)
         mem <= init_mem;
      else if (mem_wr_en)
         mem[mem_addr] <= mem_wr_data;
      rd_q <= mem[mem_addr];
   end
   assign mem_rd_data = rd_q;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Model of one run, derived from the config held in init_mem.
   logic [7:0] exp_data [64];
   int         exp_cyc  [64];
   bit         exp_msg  [64];
   int         exp_rd   [64];
   int         exp_done;

   function automatic int parity7(input int v);
      int c = 0;
      for (int b = 0; b < 7; b++) c += (v >> b) & 1;
      return c % 2;
   endfunction

   task automatic build_model();
      int pre, taps, l, t, p, e;
      pre  = int'(init_mem[61]);
      taps = int'(init_mem[62]) & 127;
      l    = int'(init_mem[63]) & 127;
      t    = 7;
      for (int i = 0; i < 64; i++) begin
         exp_msg[i] = (i >= pre) && (i - pre < 52);
         p = 0;
         exp_rd[i] = 0;
         if (exp_msg[i]) begin
            p = (int'(init_mem[i - pre]) - 32) & 255;
            exp_rd[i] = i - pre;
         end
         e = (p ^ l) & 127;
         exp_data[i] = 8'(parity7(e) * 128 + e);
         t += exp_msg[i] ? 2 : 1;
         exp_cyc[i] = t - 1;
         l = ((l << 1) | parity7(l & taps)) & 127;
      end
      exp_done = t;
   endtask

   // Compare process: cyc 0 is the first cycle Start=0 is seen in IDLE.
   bit         armed = 1'b0;
   int         cyc = 0;
   int         wr_count = 0;
   logic [7:0] prev_addr = 8'h00;

   always @(negedge Clk) begin
      if (!armed) begin
         cyc      <= 0;
         wr_count <= 0;
         check("no_write_when_idle", int'(mem_wr_en), 0);
      end else begin
         cyc       <= cyc + 1;
         prev_addr <= mem_addr;
         if (cyc == exp_done - 1)
            check("ack_before_done", int'(Ack), 0);
         if (cyc >= exp_done && cyc <= exp_done + 4)
            check($sformatf("ack_held@%0d", cyc), int'(Ack), 1);
         if (mem_wr_en) begin
            wr_count <= wr_count + 1;
            if (wr_count >= 64) begin
               check("extra_write", wr_count, 63);
            end else begin
               check($sformatf("wr_addr[%0d]", wr_count), int'(mem_addr), 64 + wr_count);
               check($sformatf("wr_data[%0d]", wr_count), int'(mem_wr_data), int'(exp_data[wr_count]));
               check($sformatf("wr_cycle[%0d]", wr_count), cyc, exp_cyc[wr_count]);
               if (exp_msg[wr_count])
                  check($sformatf("rd_addr[%0d]", wr_count), int'(prev_addr), exp_rd[wr_count]);
            end
         end
      end
   end

   task automatic set_cfg(input int pre, input int taps, input int init);
      init_mem[61] = 8'(pre);
      init_mem[62] = 8'(taps);
      init_mem[63] = 8'(init);
      for (int a = 64; a < 256; a++) init_mem[a] = 8'hEE;
   endtask

   task automatic fill_spaces();
      for (int a = 0; a < 52; a++) init_mem[a] = 8'h20;
      for (int a = 52; a < 61; a++) init_mem[a] = 8'h5A;
   endtask

   task automatic load_mem();
      do_load = 1'b1;
      @(posedge Clk); #1;
      do_load = 1'b0;
   endtask

   task automatic start_run();
      build_model();
      @(posedge Clk); #1;
      Start = 1'b0;
      armed = 1'b1;
   endtask

   task automatic finish_run();
      for (int k = 0; k < 400 && cyc <= exp_done + 4; k++) @(posedge Clk);
      #1;
      check("write_count", wr_count, 64);
      Start = 1'b1;
      armed = 1'b0;
      @(posedge Clk); #1;
      check("ack_cleared", int'(Ack), 0);
   endtask

   task automatic run_full();
      load_mem();
      start_run();
      finish_run();
   endtask

   localparam logic [7:0] T2_HEAD [10] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90,
                                           8'hA0, 8'h41, 8'h03, 8'h06, 8'h0C};

   initial begin
      Reset = 1'b1;
      Start = 1'b1;
      for (int a = 0; a < 256; a++) init_mem[a] = 8'h00;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_ack", int'(Ack), 0);
      check("rst_wr_en", int'(mem_wr_en), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_wr_data", int'(mem_wr_data), 0);
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;

      // 1: all-space message, pre=10
      fill_spaces();
      set_cfg(10, 8'h7E, 8'h01);
      run_full();
      check("t1_model_out0", int'(exp_data[0]), 8'h81);
      check("t1_out0", int'(mem[64]), 8'h81);
      check("t1_out1", int'(mem[65]), 8'h82);
      check("t1_latency", exp_done, 123);

      // 2: 'A' as the first message character
      fill_spaces();
      init_mem[0] = 8'h41;
      set_cfg(10, 8'h60, 8'h01);
      run_full();
      check("t2_model_out10", int'(exp_data[10]), 8'h39);
      check("t2_out10", int'(mem[74]), 8'h39);
      for (int k = 0; k < 10; k++) begin
         logic [7:0] hv;
         hv = T2_HEAD[k];
         check($sformatf("t2_out%0d", k), int'(mem[64 + k]), int'(hv));
      end

      // 3: random strings, taps, init and pre in 10..15
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 52; a++) init_mem[a] = 8'($urandom_range(32, 126));
         set_cfg($urandom_range(10, 15), $urandom_range(0, 127), $urandom_range(1, 127));
         run_full();
      end

      // 4: window boundaries
      fill_spaces();
      init_mem[0] = 8'h7A;
      set_cfg(63, 8'h41, 8'h25);
      run_full();
      check("t4_pre63_latency", exp_done, 72);
      set_cfg(70, 8'h41, 8'h25);
      run_full();
      check("t4_pre70_latency", exp_done, 71);
      set_cfg(200, 8'h12, 8'h7F);
      run_full();
      set_cfg(0, 8'h5C, 8'h33);
      run_full();
      check("t4_pre0_latency", exp_done, 123);
      set_cfg(70, 8'h7E, 8'h00);
      run_full();
      check("t4_zero_init_first", int'(mem[64]), 0);
      check("t4_zero_init_last", int'(mem[127]), 0);

      // 5: abort at byte 20, then rerun with a new config
      for (int a = 0; a < 52; a++) init_mem[a] = 8'(8'h30 + (a % 40));
      set_cfg(12, 8'h60, 8'h05);
      load_mem();
      start_run();
      for (int k = 0; k < 300 && wr_count < 20; k++) begin
         @(negedge Clk); #1;
      end
      check("t5_abort_point", wr_count, 20);
      Start = 1'b1;
      armed = 1'b0;
      repeat (4) begin
         @(posedge Clk); #1;
         check("t5_ack_after_abort", int'(Ack), 0);
      end
      check("t5_byte20_unwritten", int'(mem[84]), 8'hEE);
      set_cfg(14, 8'h3A, 8'h11);
      run_full();

      // 6: reset in the middle of a CH_WR cycle
      set_cfg(11, 8'h60, 8'h09);
      load_mem();
      start_run();
      for (int k = 0; k < 300 && wr_count < 5; k++) begin
         @(negedge Clk); #1;
      end
      check("t6_in_ch_wr", int'(mem_wr_en), 1);
      Reset = 1'b1;
      Start = 1'b1;
      armed = 1'b0;
      #1;
      check("t6_rst_wr_en", int'(mem_wr_en), 0);
      check("t6_rst_addr", int'(mem_addr), 0);
      check("t6_rst_wr_data", int'(mem_wr_data), 0);
      check("t6_rst_ack", int'(Ack), 0);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      repeat (4) begin
         @(posedge Clk); #1;
         check("t6_ack_after_rst", int'(Ack), 0);
      end
      check("t6_byte4_unwritten", int'(mem[68]), 8'hEE);
      set_cfg(15, 8'h71, 8'h2B);
      run_full();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
